// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// Package constant
// Shared types and frame constants for the buffered UART transmitter.
//   tx_state_t       : transmit FSM state encoding
//   UART_DATA_BITS   : data bits per frame
//   UART_FRAME_BITS  : total bit periods per frame (start + data [+ parity] + stop)
//   even_parity()    : XOR of the data bits
// Optional feature macro: UART_TX_PARITY_EN adds a PARITY state and one bit
// period of even parity between the data bits and the stop bit.
// ---------------------------------------------------------------------------
package constant;

  localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 3;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte write channel from the execute stage into the transmit FIFO.
//   wdata  : byte to transmit
//   wvalid : push request
//   wready : FIFO not full; a push happens on an edge with wvalid && wready
// Modports: master (producer), slave (uart_tx_fifo).
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/uart_tx_fifo_tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Synchronous circular-buffer FIFO, 2**DEPTH_LOG2 entries.
//   clk, rstn : clock, asynchronous active-low reset
//   push, din : write request and data (ignored when full)
//   pop, dout : read request and head entry (ignored when empty)
//   full, empty, count : occupancy status
// The head entry is presented combinationally so the transmitter can load it
// on the same edge it pops; at this depth the array maps to distributed RAM.
// ---------------------------------------------------------------------------
module tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: bytes pushed through the write interface are
// queued in tx_fifo and serialised LSB first as 8N1 frames, back to back.
//   clk   : clock (rising edge)
//   rstn  : asynchronous active-low reset; abandons any frame in flight
//   wr    : uart_tx_fifo_if.slave (wdata / wvalid / wready)
//   txd   : serial line, registered, idles high
//   busy  : frame on the line or FIFO non-empty
//   count : FIFO occupancy
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import constant::*;
#(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic                clk,
  input  logic                rstn,
  uart_tx_fifo_if.slave       wr,
  output logic                txd,
  output logic                busy,
  output logic [DEPTH_LOG2:0] count
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int BAUD_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t   state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic        load;
  logic        pop;
  logic        push;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  assign push      = wr.wvalid && !fifo_full;
  assign wr.wready = !fifo_full;
  assign bit_end   = (baud_reg == BAUD_LAST);
  assign busy      = (state_reg != IDLE) || !fifo_empty;
  assign txd       = txd_reg;

  tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (wr.wdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    load       = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    if (state_reg != IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        load = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          load       = !fifo_empty;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      pop        = 1'b1;
      shift_next = fifo_dout;
      bit_next   = '0;
      baud_next  = '0;
      state_next = START;
`ifdef UART_TX_PARITY_EN
      parity_next = even_parity(fifo_dout);
`endif
    end

    // The line value is derived from the next state so that txd changes on
    // the same edge as the state register.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with CLK_PER_HALF_BIT=4 (8 clocks per bit).
// A behavioural receiver samples txd at bit centres and queues decoded bytes.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPH      = 4;
  localparam int BIT_CLKS = 2 * CPH;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic       clk;
  logic       rstn;
  logic       txd;
  logic       busy;
  logic [4:0] count;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_PER_HALF_BIT (CPH),
    .DEPTH_LOG2       (4)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (bus),
    .txd   (txd),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural receiver
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_err   = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt   = 0;
  int         rx_bit   = 0;
  int         rx_start = 0;
  logic [7:0] rx_byte  = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_start  = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BIT_CLKS == BIT_CLKS / 2) begin
        rx_bit = rx_cnt / BIT_CLKS;
        if (rx_bit == 0) begin
          if (txd !== 1'b0) rx_err++;
        end else if (rx_bit <= 8) begin
          rx_byte[rx_bit-1] = txd;
        end else if (rx_bit < FRAME_BITS - 1) begin
          if (txd !== ^rx_byte) rx_err++;
        end else begin
          if (txd !== 1'b1) rx_err++;
          rx_q.push_back(rx_byte);
          rx_t.push_back(rx_start);
          $display("rx byte 0x%02h at cycle %0d", rx_byte, rx_start);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    $display("push 0x%02h", b);
    bus.wdata  = b;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout_busy", 32'(busy), 32'(0));
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_err = 0;
  endtask

  // Push one byte from idle and check the line every clock of the frame.
  task automatic single_frame(input logic [7:0] b, input logic par_exp);
    logic [10:0] fr;
    int t0;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    if (FRAME_BITS == 11) fr[9] = par_exp;
    clear_rx();
    push_byte(b);
    check("push_count", 32'(count), 32'(1));
    check("push_busy", 32'(busy), 32'(1));
    check("push_txd_still_high", 32'(txd), 32'(1));
    tick();
    t0 = cyc;
    check("start_txd", 32'(txd), 32'(0));
    check("pop_count", 32'(count), 32'(0));
    for (int j = 1; j < FRAME_CLKS; j++) begin
      tick();
      check($sformatf("line_bit%0d_clk%0d", j / BIT_CLKS, j % BIT_CLKS),
            32'(txd), 32'(fr[j / BIT_CLKS]));
    end
    check("busy_last_stop_clk", 32'(busy), 32'(1));
    tick();
    check("end_busy", 32'(busy), 32'(0));
    check("end_txd", 32'(txd), 32'(1));
    check("frame_clks", 32'(cyc - t0), 32'(FRAME_CLKS));
    check("single_rx_n", 32'(rx_q.size()), 32'(1));
    if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'(b));
    check("single_rx_err", 32'(rx_err), 32'(0));
  endtask

  initial begin
    int   b;
    int   guard;
    logic w;
    logic saw_low;

    rstn       = 1'b0;
    bus.wdata  = '0;
    bus.wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_wready", 32'(bus.wready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    rstn = 1'b1;
    tick();

    // Single byte 0x55 (four ones -> even parity 0)
    single_frame(8'h55, 1'b0);

    // Back-to-back 0xA5, 0x3C
    clear_rx();
    $display("push 0xa5, 0x3c back to back");
    bus.wdata  = 8'hA5;
    bus.wvalid = 1'b1;
    tick();
    bus.wdata  = 8'h3C;
    tick();
    bus.wvalid = 1'b0;
    check("b2b_count", 32'(count), 32'(1));
    wait_idle(400);
    check("b2b_rx_n", 32'(rx_q.size()), 32'(2));
    if (rx_q.size() == 2) begin
      check("b2b_rx0", 32'(rx_q[0]), 32'(8'hA5));
      check("b2b_rx1", 32'(rx_q[1]), 32'(8'h3C));
      check("b2b_gap", 32'(rx_t[1] - rx_t[0]), 32'(FRAME_CLKS));
      check("b2b_total", 32'(cyc - rx_t[0]), 32'(2 * FRAME_CLKS));
    end
    check("b2b_rx_err", 32'(rx_err), 32'(0));

    // Full: 17 bytes with wvalid held high
    clear_rx();
    b = 0;
    guard = 0;
    while (b < 17 && guard < 200) begin
      bus.wdata  = 8'(b);
      bus.wvalid = 1'b1;
      w = bus.wready;
      tick();
      if (w) begin
        $display("push 0x%02h", 8'(b));
        b++;
      end
      guard++;
    end
    bus.wvalid = 1'b0;
    check("full_pushed", 32'(b), 32'(17));
    check("full_count", 32'(count), 32'(16));
    check("full_wready", 32'(bus.wready), 32'(0));
    guard = 0;
    while (bus.wready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("full_wready_back", 32'(bus.wready), 32'(1));
    check("full_count_after_pop", 32'(count), 32'(15));
    wait_idle(17 * FRAME_CLKS + 100);
    check("full_rx_n", 32'(rx_q.size()), 32'(17));
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      check($sformatf("full_rx%0d", i), 32'(rx_q[i]), 32'(i));
    end
    check("full_rx_err", 32'(rx_err), 32'(0));

    // Wrap-around: 40 bytes in bursts of 10
    clear_rx();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) begin
        push_byte(8'(k * 10 + i));
      end
      wait_idle(10 * FRAME_CLKS + 100);
    end
    check("wrap_rx_n", 32'(rx_q.size()), 32'(40));
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      check($sformatf("wrap_rx%0d", i), 32'(rx_q[i]), 32'(i));
    end
    check("wrap_count", 32'(count), 32'(0));
    check("wrap_rx_err", 32'(rx_err), 32'(0));

    // Reset during data bit 3 of 0xFF with two bytes queued
    clear_rx();
    $display("push 0xff, 0x01, 0x02 then reset mid-frame");
    bus.wvalid = 1'b1;
    bus.wdata  = 8'hFF;
    tick();
    bus.wdata  = 8'h01;
    tick();
    bus.wdata  = 8'h02;
    tick();
    bus.wvalid = 1'b0;
    check("rstmid_count_before", 32'(count), 32'(2));
    repeat (33) @(posedge clk);
    #1;
    check("rstmid_busy_before", 32'(busy), 32'(1));
    rstn = 1'b0;
    #1;
    check("rstmid_txd", 32'(txd), 32'(1));
    check("rstmid_count", 32'(count), 32'(0));
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_wready", 32'(bus.wready), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("rstmid_line_quiet", 32'(saw_low), 32'(0));
    check("rstmid_rx_n", 32'(rx_q.size()), 32'(0));

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones -> parity bit 1, frame 88 clocks
    single_frame(8'h07, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
